store_buffer: RTL and testbench

- Posted-write buffer between the execute/memory stage of the 8-bit nRISC core and `data_memory`.
- Stores are queued in a small in-order FIFO and retired into `data_memory` on cycles when the memory port is not needed for a load.
- Loads see their own pending stores by forwarding from the youngest matching entry, so the CPU never reads stale data.
- The block owns the single address/write port of `data_memory`.

---
 rtl/store_buffer.sv | 101 ++++++++++
 tb/tb_store_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer between the nRISC memory stage and data_memory.
// In-order FIFO that drains on load-free cycles and forwards pending stores to loads.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic [7:0]    CpuAddress,
   input  logic [7:0]    CpuWriteData,
   input  logic          CpuWrite,
   input  logic          CpuRead,
   output logic [7:0]    CpuReadData,
   output logic          Stall,
   output logic [7:0]    MemAddress,
   output logic [7:0]    MemWriteData,
   output logic          MemWrite,
   input  logic [7:0]    MemData,
   output logic          Empty,
   output logic          Full,
   output logic [CW-1:0] Count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]       r_addr [DEPTH];
   logic [7:0]       r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic             w_empty;
   logic             w_full;
   logic             w_stall;
   logic             w_push;
   logic             w_pop;
   logic             w_fwd_hit;
   logic [7:0]       w_fwd_data;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));

   // A load owns the memory port, so a full buffer can only refuse a store while a load is present.
   assign w_stall = !Reset && CpuWrite && CpuRead && w_full;
   assign w_pop   = !Reset && !CpuRead && !w_empty;
   assign w_push  = !Reset && CpuWrite && !w_stall;

   assign Stall        = w_stall;
   assign MemWrite     = w_pop;
   assign MemAddress   = w_pop ? r_addr[r_head] : CpuAddress;
   assign MemWriteData = w_pop ? r_data[r_head] : 8'h00;
   assign Empty        = Reset || w_empty;
   assign Full         = !Reset && w_full;
   assign Count        = r_count;
   assign CpuReadData  = w_fwd_data;

   // Walk from the youngest entry (tail-1) towards head; the first match wins.
   always_comb begin
      // NOTE: defaults first so no path through this block leaves a latch.
      w_fwd_hit  = 1'b0;
      w_fwd_data = MemData;
      for (int i = 0; i < DEPTH; i++) begin
         if (!w_fwd_hit && (CW'(i) < r_count) && r_valid[r_tail - PW'(i + 1)] &&
             (r_addr[r_tail - PW'(i + 1)] == CpuAddress)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[r_tail - PW'(i + 1)];
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         // Pop before push: when full, head == tail and the new entry must stay valid.
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // NOTE: the payload array is not reset; valid bits and count already mark it as empty.
   always_ff @(posedge Clock) begin
      if (w_push) begin
         r_addr[r_tail] <= CpuAddress;
         r_data[r_tail] <= CpuWriteData;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          Clock;
   logic          Reset;
   logic [7:0]    CpuAddress;
   logic [7:0]    CpuWriteData;
   logic          CpuWrite;
   logic          CpuRead;
   logic [7:0]    CpuReadData;
   logic          Stall;
   logic [7:0]    MemAddress;
   logic [7:0]    MemWriteData;
   logic          MemWrite;
   logic [7:0]    MemData;
   logic          Empty;
   logic          Full;
   logic [CW-1:0] Count;

   store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .CpuAddress  (CpuAddress),
      .CpuWriteData(CpuWriteData),
      .CpuWrite    (CpuWrite),
      .CpuRead     (CpuRead),
      .CpuReadData (CpuReadData),
      .Stall       (Stall),
      .MemAddress  (MemAddress),
      .MemWriteData(MemWriteData),
      .MemWrite    (MemWrite),
      .MemData     (MemData),
      .Empty       (Empty),
      .Full        (Full),
      .Count       (Count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // data_memory stand-in driven by the DUT
   logic [7:0] mem [256];
   assign MemData = mem[MemAddress];
   always @(posedge Clock) if (MemWrite) mem[MemAddress] <= MemWriteData;

   // Reference model: pending stores in program order, and the memory image they must produce
   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } ent_t;
   ent_t       mq [$];
   logic [7:0] ref_mem [256];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] preload(input int a);
      if (a == 8'h31) return 8'h7E;
      if (a == 8'h50) return 8'h0F;
      return 8'(a) ^ 8'hC3;
   endfunction

   // Compare process: inputs change at posedge+2, outputs are sampled at the falling edge.
   int         n;
   logic       e_drain;
   logic       e_stall;
   logic [7:0] e_rd;
   always @(negedge Clock) begin
      n = mq.size();
      if (Reset) begin
         check("rst_memwrite", 32'(MemWrite), 0);
         check("rst_stall", 32'(Stall), 0);
         check("rst_empty", 32'(Empty), 1);
         check("rst_full", 32'(Full), 0);
         check("rst_memaddr", 32'(MemAddress), 32'(CpuAddress));
         check("rst_memwdata", 32'(MemWriteData), 0);
         mq.delete();
      end else begin
         e_stall = CpuWrite && CpuRead && (n == DEPTH);
         e_drain = !CpuRead && (n > 0);
         check("count", 32'(Count), 32'(n));
         check("empty", 32'(Empty), 32'(n == 0));
         check("full", 32'(Full), 32'(n == DEPTH));
         check("stall", 32'(Stall), 32'(e_stall));
         check("memwrite", 32'(MemWrite), 32'(e_drain));
         if (e_drain) begin
            check("drain_addr", 32'(MemAddress), 32'(mq[0].addr));
            check("drain_data", 32'(MemWriteData), 32'(mq[0].data));
         end else begin
            check("memaddr", 32'(MemAddress), 32'(CpuAddress));
         end
         if (CpuRead) begin
            e_rd = ref_mem[CpuAddress];
            for (int i = 0; i < n; i++)
               if (mq[i].addr == CpuAddress) e_rd = mq[i].data;
            check("readdata", 32'(CpuReadData), 32'(e_rd));
         end
         if (e_drain) begin
            ref_mem[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
         end
         if (CpuWrite && !e_stall) mq.push_back('{CpuAddress, CpuWriteData});
      end
   end

   task automatic tick();
      @(posedge Clock);
      #2;
   endtask

   task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
      CpuWrite     = w;
      CpuRead      = r;
      CpuAddress   = a;
      CpuWriteData = d;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = preload(i);
         ref_mem[i] = preload(i);
      end
      Reset = 1'b1;
      drive(0, 0, 8'h00, 8'h00);
      tick();
      tick();
      Reset = 1'b0;
      #1;
      check("post_reset_count", 32'(Count), 0);
      check("post_reset_empty", 32'(Empty), 1);

      // single store reaches memory one edge after presentation at head
      drive(1, 0, 8'h10, 8'hA5);
      tick();
      drive(0, 0, 8'h00, 8'h00);
      #1;
      check("t1_count", 32'(Count), 1);
      check("t1_memwrite", 32'(MemWrite), 1);
      check("t1_memaddr", 32'(MemAddress), 32'h10);
      check("t1_memwdata", 32'(MemWriteData), 32'hA5);
      tick();
      #1;
      check("t1_mem10", 32'(mem[8'h10]), 32'hA5);
      check("t1_empty", 32'(Empty), 1);

      // fill while a load holds the port, then stall on the fifth store
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 8'h00, 8'h00);
         CpuAddress   = 8'h00;
         CpuWriteData = 8'(i + 1);
         CpuAddress   = 8'(8'h20 + i);
         tick();
      end
      drive(1, 1, 8'h24, 8'h05);
      #1;
      check("t2_full", 32'(Full), 1);
      check("t2_count", 32'(Count), 4);
      check("t2_stall", 32'(Stall), 1);
      tick();
      #1;
      check("t2_count_held", 32'(Count), 4);
      drive(0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_drain_addr", 32'(MemAddress), 32'(8'h20 + i));
         check("t2_drain_data", 32'(MemWriteData), 32'(i + 1));
         tick();
      end
      #1;
      for (int i = 0; i < 4; i++) check("t2_mem", 32'(mem[8'h20 + i]), 32'(i + 1));
      check("t2_mem24_untouched", 32'(mem[8'h24]), 32'(8'h24 ^ 8'hC3));

      // youngest matching entry wins; a miss falls through to memory
      drive(1, 1, 8'h30, 8'h11);
      tick();
      drive(1, 1, 8'h30, 8'h22);
      tick();
      drive(0, 1, 8'h30, 8'h00);
      #1;
      check("t3_fwd_youngest", 32'(CpuReadData), 32'h22);
      CpuAddress = 8'h31;
      #1;
      check("t3_miss", 32'(CpuReadData), 32'h7E);
      drive(0, 0, 8'h00, 8'h00);
      repeat (3) tick();

      // full buffer: store with no load pushes and pops at the same edge
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 8'(8'h40 + i), 8'(8'h80 + i));
         tick();
      end
      drive(1, 0, 8'h40, 8'h99);
      #1;
      check("t4_stall", 32'(Stall), 0);
      check("t4_drain_head", 32'(MemAddress), 32'h40);
      tick();
      #1;
      check("t4_count", 32'(Count), 4);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         drive(1, 0, 8'(8'h60 + i), 8'(i * 3 + 1));
         tick();
      end
      drive(0, 0, 8'h00, 8'h00);
      repeat (6) tick();
      #1;
      check("t4_mem40_last", 32'(mem[8'h40]), 32'h99);
      check("t4_mem6b", 32'(mem[8'h6B]), 32'h22);

      // same-cycle load does not see the same-cycle store
      drive(1, 1, 8'h50, 8'hF0);
      #1;
      check("t5_no_bypass", 32'(CpuReadData), 32'h0F);
      tick();
      drive(0, 1, 8'h50, 8'h00);
      #1;
      check("t5_fwd", 32'(CpuReadData), 32'hF0);
      drive(0, 0, 8'h00, 8'h00);
      repeat (2) tick();

      // reset discards pending stores
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 8'(8'h70 + i), 8'(8'hAA + i * 17));
         tick();
      end
      drive(0, 0, 8'h00, 8'h00);
      Reset = 1'b1;
      #1;
      check("t6_memwrite_rst", 32'(MemWrite), 0);
      check("t6_empty_rst", 32'(Empty), 1);
      tick();
      Reset = 1'b0;
      #1;
      check("t6_count", 32'(Count), 0);
      check("t6_empty", 32'(Empty), 1);
      repeat (4) tick();
      for (int i = 0; i < 3; i++) check("t6_discarded", 32'(mem[8'h70 + i]), 32'(8'(8'h70 + i) ^ 8'hC3));

      // final memory image must equal the program-order model
      for (int i = 0; i < 256; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
